// File: rtl/sync_gen_ctrl.sv
// rtl/sync_gen_ctrl.sv - sync pulse sequencer with arm/external-sync control
//
// Purpose:
//   Arms a periodic sync generator from a software control word, either
//   immediately or on the next rising edge of an external sync input, then
//   emits one-cycle pulses every period_in cycles. Reports a pulse count,
//   the current state and a sticky illegal-period flag.
//
// Ports:
//   user_clk     in   clock, rising edge
//   user_rst     in   synchronous active-high reset
//   period_in    in   sync period in cycles (sampled at pulse boundaries)
//   ctrl_in      in   [0] enable, [1] arm (rising edge), [2] ext_mode
//   ext_sync_in  in   external sync, already in the user_clk domain
//   sync_out     out  one-cycle sync pulse
//   sync_count   out  pulses since last arm, wraps modulo 2^PERIOD_W
//   state_out    out  0 = IDLE, 1 = WAIT_EXT, 2 = RUN
//   period_err   out  sticky, set when an illegal period is latched

module sync_gen_ctrl #(
  parameter int PERIOD_W   = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [31:0]         ctrl_in,
  input  logic                ext_sync_in,
  output logic                sync_out,
  output logic [PERIOD_W-1:0] sync_count,
  output logic [1:0]          state_out,
  output logic                period_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_EXT = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam logic [PERIOD_W-1:0] LP_MIN_PERIOD = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] LP_ONE        = PERIOD_W'(1);

  // Registered state
  logic [1:0]          r_state;
  logic                r_arm_q;
  logic                r_ext_q;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] r_count;
  logic                r_err;
  logic                r_sync;

  // Decoded control and edges
  logic w_enable;
  logic w_arm_in;
  logic w_ext_mode;
  logic w_arm_rise;
  logic w_ext_rise;
  logic w_per_ok;
  logic w_unused_ctrl;

  // Next-state values
  logic [1:0]          w_state_nxt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [PERIOD_W-1:0] w_per_nxt;
  logic [PERIOD_W-1:0] w_count_nxt;
  logic                w_err_nxt;
  logic                w_sync_nxt;
  logic                w_boundary;

  assign w_enable      = ctrl_in[0];
  assign w_arm_in      = ctrl_in[1];
  assign w_ext_mode    = ctrl_in[2];
  assign w_unused_ctrl = ^ctrl_in[31:3];

  assign w_arm_rise = w_arm_in & ~r_arm_q;
  assign w_ext_rise = ext_sync_in & ~r_ext_q;

  // The period is judged on the value being latched at this boundary.
  assign w_per_ok = (period_in >= LP_MIN_PERIOD);

  // A "pulse pending" boundary is resolved on the same edge that creates it,
  // so the pulse is visible in the cycle right after the arm or ext edge and
  // sync_out / sync_count change together.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_sync_nxt  = 1'b0;
    w_boundary  = 1'b0;

    if (!w_enable) begin
      // Disable beats any simultaneous arm edge; count and error hold.
      w_state_nxt = ST_IDLE;
    end else if (w_arm_rise) begin
      // Arm restarts from any state; a coincident ext edge or terminal
      // count is consumed by the restart.
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
      if (w_ext_mode) begin
        w_state_nxt = ST_WAIT_EXT;
      end else begin
        w_boundary = 1'b1;
      end
    end else begin
      case (r_state)
        ST_WAIT_EXT: begin
          if (w_ext_rise) begin
            w_boundary = 1'b1;
          end
        end
        ST_RUN: begin
          // Loaded with P-1 on a pulse; the boundary falls on the cycle
          // after it has counted down to zero, giving P-cycle spacing.
          if (r_cnt == '0) begin
            w_boundary = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (w_boundary) begin
      w_per_nxt = period_in;
      if (!w_per_ok) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_sync_nxt  = 1'b1;
        w_cnt_nxt   = period_in - LP_ONE;
        w_count_nxt = w_count_nxt + LP_ONE;
        w_state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state <= ST_IDLE;
      r_arm_q <= 1'b0;
      r_ext_q <= 1'b0;
      r_cnt   <= '0;
      r_per   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_arm_q <= w_arm_in;
      r_ext_q <= ext_sync_in;
      r_cnt   <= w_cnt_nxt;
      r_per   <= w_per_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_sync  <= w_sync_nxt;
    end
  end

  assign sync_out   = r_sync;
  assign sync_count = r_count;
  assign state_out  = r_state;
  assign period_err = r_err;

endmodule

// File: tb/tb_sync_gen_ctrl.sv
// tb/tb_sync_gen_ctrl.sv - self-checking bench for sync_gen_ctrl
module tb_sync_gen_ctrl;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] period_in;
  logic [31:0] ctrl_in;
  logic        ext_sync_in;

  logic        sync_out0, period_err0;
  logic [31:0] sync_count0;
  logic [1:0]  state_out0;
  logic        sync_out1, period_err1;
  logic [3:0]  sync_count1;
  logic [1:0]  state_out1;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  // Reference state: index 0 = 32-bit instance, index 1 = 4-bit instance.
  int     m_mode [2];
  longint m_next [2];
  longint m_count[2];
  logic   m_err  [2];
  logic   m_sync [2];
  logic   m_parm [2];
  logic   m_pext [2];

  always #5 user_clk = ~user_clk;

  sync_gen_ctrl #(.PERIOD_W(32), .MIN_PERIOD(2)) dut0 (
    .user_clk(user_clk), .user_rst(user_rst), .period_in(period_in),
    .ctrl_in(ctrl_in), .ext_sync_in(ext_sync_in), .sync_out(sync_out0),
    .sync_count(sync_count0), .state_out(state_out0), .period_err(period_err0)
  );

  sync_gen_ctrl #(.PERIOD_W(4), .MIN_PERIOD(2)) dut1 (
    .user_clk(user_clk), .user_rst(user_rst), .period_in(period_in[3:0]),
    .ctrl_in(ctrl_in), .ext_sync_in(ext_sync_in), .sync_out(sync_out1),
    .sync_count(sync_count1), .state_out(state_out1), .period_err(period_err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Pulse boundary: latch the period and either pulse or flag an error.
  task automatic m_start(input int k);
    longint p;
    longint modv;
    modv = (k == 0) ? 64'h1_0000_0000 : 64'd16;
    p = longint'(period_in) % modv;
    if (p < 2) begin
      m_err[k]  = 1'b1;
      m_mode[k] = 0;
    end else begin
      m_sync[k]  = 1'b1;
      m_count[k] = (m_count[k] + 1) % modv;
      m_next[k]  = cyc + p;
      m_mode[k]  = 2;
    end
  endtask

  task automatic model_step(input int k);
    logic arm_rise, ext_rise;
    arm_rise = ctrl_in[1] & ~m_parm[k];
    ext_rise = ext_sync_in & ~m_pext[k];
    m_parm[k] = ctrl_in[1];
    m_pext[k] = ext_sync_in;
    m_sync[k] = 1'b0;
    if (user_rst) begin
      m_mode[k] = 0; m_count[k] = 0; m_err[k] = 1'b0;
      m_parm[k] = 1'b0; m_pext[k] = 1'b0;
    end else if (!ctrl_in[0]) begin
      m_mode[k] = 0;
    end else if (arm_rise) begin
      m_count[k] = 0;
      m_err[k]   = 1'b0;
      if (ctrl_in[2]) m_mode[k] = 1;
      else m_start(k);
    end else if (m_mode[k] == 1 && ext_rise) begin
      m_start(k);
    end else if (m_mode[k] == 2 && cyc == m_next[k]) begin
      m_start(k);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    check_eq("sync0",  {31'd0, sync_out0},   {31'd0, m_sync[0]});
    check_eq("count0", sync_count0,          m_count[0][31:0]);
    check_eq("state0", {30'd0, state_out0},  32'(m_mode[0]));
    check_eq("err0",   {31'd0, period_err0}, {31'd0, m_err[0]});
    check_eq("sync1",  {31'd0, sync_out1},   {31'd0, m_sync[1]});
    check_eq("count1", {28'd0, sync_count1}, m_count[1][31:0]);
    check_eq("state1", {30'd0, state_out1},  32'(m_mode[1]));
    check_eq("err1",   {31'd0, period_err1}, {31'd0, m_err[1]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_next[k] = 0; m_count[k] = 0;
      m_err[k] = 1'b0; m_sync[k] = 1'b0; m_parm[k] = 1'b0; m_pext[k] = 1'b0;
    end
    user_rst = 1'b1; period_in = 32'd8; ctrl_in = 32'd0; ext_sync_in = 1'b0;
    ticks(2);
    check_eq("reset_state", {30'd0, state_out0}, 32'd0);
    check_eq("reset_count", sync_count0, 32'd0);
    user_rst = 1'b0;
    tick();

    // Internal mode, P=8: pulses at arm+1, +9, +17
    ctrl_in = 32'h1; tick();
    ctrl_in = 32'h3; tick();
    check_eq("int_first_pulse", {31'd0, sync_out0}, 32'd1);
    ticks(16);
    check_eq("int_third_pulse", {31'd0, sync_out0}, 32'd1);
    check_eq("int_count3", sync_count0, 32'd3);
    ticks(3);

    // External mode, P=5
    ctrl_in = 32'h1; tick();
    period_in = 32'd5;
    ctrl_in = 32'h5; tick();
    ctrl_in = 32'h7; tick();
    ticks(20);
    check_eq("ext_waiting", {30'd0, state_out0}, 32'd1);
    ext_sync_in = 1'b1; tick();
    check_eq("ext_first_pulse", {31'd0, sync_out0}, 32'd1);
    ext_sync_in = 1'b0;
    ticks(12);

    // Period change mid-interval: 10 then 4
    ctrl_in = 32'h1; period_in = 32'd10; tick();
    ctrl_in = 32'h3; tick();
    ticks(4);
    period_in = 32'd4;
    ticks(20);

    // Illegal period, then legal re-arm
    ctrl_in = 32'h1; period_in = 32'd1; tick();
    ctrl_in = 32'h3; tick();
    check_eq("illegal_err", {31'd0, period_err0}, 32'd1);
    check_eq("illegal_state", {30'd0, state_out0}, 32'd0);
    check_eq("illegal_nopulse", {31'd0, sync_out0}, 32'd0);
    ctrl_in = 32'h1; period_in = 32'd6; tick();
    ctrl_in = 32'h3; tick();
    check_eq("rearm_err_clear", {31'd0, period_err0}, 32'd0);
    ticks(20);

    // Disable in RUN, then reset mid-period
    ctrl_in = 32'h2; tick();
    check_eq("disable_idle", {30'd0, state_out0}, 32'd0);
    ticks(10);
    ctrl_in = 32'h0; tick();
    ctrl_in = 32'h1; tick();
    ctrl_in = 32'h3; ticks(3);
    user_rst = 1'b1; tick();
    check_eq("rst_mid_count", sync_count0, 32'd0);
    check_eq("rst_mid_sync", {31'd0, sync_out0}, 32'd0);
    user_rst = 1'b0; ctrl_in = 32'h0;
    ticks(5);

    // Re-arm while running restarts phase and count
    ctrl_in = 32'h1; period_in = 32'd7; tick();
    ctrl_in = 32'h3; ticks(10);
    ctrl_in = 32'h1; tick();
    ctrl_in = 32'h3; tick();
    check_eq("rearm_count", sync_count0, 32'd1);
    check_eq("rearm_pulse", {31'd0, sync_out0}, 32'd1);
    ticks(8);

    // Wrap on the 4-bit instance: 16 pulses at P=2 return the count to 0
    ctrl_in = 32'h1; period_in = 32'd2; tick();
    ctrl_in = 32'h3; tick();
    ticks(30);
    check_eq("wrap_count", {28'd0, sync_count1}, 32'd0);
    check_eq("wrap_pulse", {31'd0, sync_out1}, 32'd1);
    ticks(4);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) period_in = $urandom_range(0, 12);
      if ($urandom_range(0, 200) == 0) period_in = $urandom_range(16, 40);
      if ($urandom_range(0, 7) == 0) begin
        ctrl_in = {$urandom, $urandom_range(0, 1) == 0 ? 1'b0 : 1'b1,
                   $urandom_range(0, 1) == 0 ? 1'b0 : 1'b1,
                   $urandom_range(0, 9) == 0 ? 1'b0 : 1'b1} & 32'hFFFF_FFFF;
        ctrl_in[31:3] = 29'($urandom);
      end
      ext_sync_in = ($urandom_range(0, 5) == 0);
      user_rst    = ($urandom_range(0, 300) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
